// File: rtl/fp_mult_pipe_if.sv
// fp_mult_pipe_if: operand/result valid-ready bundle for fp_mult_pipe.
interface fp_mult_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, result);
  modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, result);
endinterface

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage floating-point multiplier with global stall, FTZ inputs/outputs.
// Define FP_MULT_PIPE_RNE_EN for round-to-nearest-even; default truncates.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic clk,
  input logic rst_n,
  fp_mult_pipe_if.slave io_bus
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * (MAN_W + 1);
  localparam int XW = EXP_W + 2;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam int EMAX = 2 ** EXP_W - 1;
`ifdef FP_MULT_PIPE_RNE_EN
  localparam int KW = PW;
`else
  localparam int KW = MAN_W + 2;
`endif
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  logic [EXP_W-1:0] w_ea, w_eb;
  logic w_za, w_zb, w_ia, w_ib, w_nan, w_sign, w_spec, w_adv;
  logic [W-1:0] w_sres;
  logic r_v1, r_sign1, r_sp1;
  logic [W-1:0] r_sres1;
  logic [MAN_W:0] r_ma1, r_mb1;
  logic [EXP_W-1:0] r_ea1, r_eb1;
  logic r_v2, r_sign2, r_sp2;
  logic [W-1:0] r_sres2;
  logic [KW-1:0] r_prod2, w_prod;
  logic [XW-1:0] r_exp2, w_esum;
  logic r_v3;
  logic [W-1:0] r_res;
  logic w_msb;
  logic [MAN_W-1:0] w_frac;
  logic [MAN_W:0] w_rnd;
  logic [XW-1:0] w_e;
  logic [W-1:0] w_pack;
  assign w_ea = io_bus.a[W-2:MAN_W];
  assign w_eb = io_bus.b[W-2:MAN_W];
  assign w_za = w_ea == '0;
  assign w_zb = w_eb == '0;
  assign w_ia = &w_ea && io_bus.a[MAN_W-1:0] == '0;
  assign w_ib = &w_eb && io_bus.b[MAN_W-1:0] == '0;
  assign w_nan = (&w_ea && |io_bus.a[MAN_W-1:0]) || (&w_eb && |io_bus.b[MAN_W-1:0]) ||
                 (w_ia && w_zb) || (w_ib && w_za);
  assign w_sign = io_bus.a[W-1] ^ io_bus.b[W-1];
  assign w_spec = w_nan || w_ia || w_ib || w_za || w_zb;
  assign w_sres = w_nan ? QNAN :
                  (w_ia || w_ib) ? {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                  {w_sign, {(W-1){1'b0}}};
  // Only the product bits that rounding actually consumes are kept in S2.
  assign w_prod = KW'((PW'(r_ma1) * PW'(r_mb1)) >> (PW - KW));
  assign w_esum = XW'(r_ea1) + XW'(r_eb1) - XW'(BIAS);
  assign w_msb = r_prod2[KW-1];
  assign w_frac = w_msb ? r_prod2[KW-2 -: MAN_W] : r_prod2[KW-3 -: MAN_W];
`ifdef FP_MULT_PIPE_RNE_EN
  logic [MAN_W:0] w_lo;
  assign w_lo = w_msb ? r_prod2[MAN_W:0] : {r_prod2[MAN_W-1:0], 1'b0};
  assign w_rnd = {1'b0, w_frac} + (MAN_W+1)'(w_lo[MAN_W] && (|w_lo[MAN_W-1:0] || w_frac[0]));
`else
  assign w_rnd = {1'b0, w_frac};
`endif
  // A rounding carry leaves the fraction at zero, so only the exponent moves.
  assign w_e = r_exp2 + XW'(w_msb) + XW'(w_rnd[MAN_W]);
  assign w_pack = (w_e[XW-1] || w_e == '0) ? {r_sign2, {(W-1){1'b0}}} :
                  (w_e >= XW'(EMAX)) ? {r_sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                  {r_sign2, w_e[EXP_W-1:0], w_rnd[MAN_W-1:0]};
  assign w_adv = !r_v3 || io_bus.out_ready;
  assign io_bus.in_ready = w_adv;
  assign io_bus.out_valid = r_v3;
  assign io_bus.result = r_res;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_v1, r_sign1, r_sp1, r_sres1, r_ma1, r_mb1, r_ea1, r_eb1} <= '0;
      {r_v2, r_sign2, r_sp2, r_sres2, r_prod2, r_exp2} <= '0;
      {r_v3, r_res} <= '0;
    end else if (w_adv) begin
      r_v1 <= io_bus.in_valid;
      r_sign1 <= w_sign;
      r_sp1 <= w_spec;
      r_sres1 <= w_sres;
      r_ma1 <= {1'b1, io_bus.a[MAN_W-1:0]};
      r_mb1 <= {1'b1, io_bus.b[MAN_W-1:0]};
      r_ea1 <= w_ea;
      r_eb1 <= w_eb;
      r_v2 <= r_v1;
      r_sign2 <= r_sign1;
      r_sp2 <= r_sp1;
      r_sres2 <= r_sres1;
      r_prod2 <= w_prod;
      r_exp2 <= w_esum;
      r_v3 <= r_v2;
      r_res <= r_sp2 ? r_sres2 : w_pack;
    end
  end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: scoreboard bench for fp_mult_pipe (default 8/23 format).
module tb_fp_mult_pipe;
  logic clk = 0;
  logic rst_n = 0;
  int total = 0;
  int bad = 0;
  logic [31:0] q[$];
  logic [31:0] exp_in;
  logic prev_stall = 0;
  logic [31:0] prev_res = 0;
`ifdef FP_MULT_PIPE_RNE_EN
  localparam logic [31:0] RND_EXP = 32'h3FC00002;
`else
  localparam logic [31:0] RND_EXP = 32'h3FC00001;
`endif

  fp_mult_pipe_if bus();
  fp_mult_pipe dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      chk("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
      if (bus.in_valid && bus.in_ready) q.push_back(exp_in);
      if (bus.out_valid && prev_stall) chk("hold", bus.result, prev_res);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("extra", 32'(bus.out_valid), 0);
        else chk("result", bus.result, q.pop_front());
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_res = bus.result;
    end
  end

  task automatic single(input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
    int n = 0;
    bus.a = x;
    bus.b = y;
    exp_in = e;
    bus.in_valid = 1;
    do begin
      @(posedge clk);
      #1;
      n++;
      bus.in_valid = 0;
    end while (!bus.out_valid && n < 10);
    chk("latency", n, 3);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int i, cyc, stalls;
    logic acc;
    bus.in_valid = 0;
    bus.a = 0;
    bus.b = 0;
    bus.out_ready = 1;
    exp_in = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_result", bus.result, 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    rst_n = 1;
    single(32'h40000000, 32'h40400000, 32'h40C00000);
    single(32'h3FC00000, 32'h3FC00000, 32'h40100000);
    single(32'h3F800001, 32'h3FC00000, RND_EXP);
    single(32'hC0000000, 32'h40400000, 32'hC0C00000);
    single(32'h7F800000, 32'h00000000, 32'h7FC00000);
    single(32'hFF800000, 32'h40000000, 32'hFF800000);
    single(32'h7F000000, 32'h7F000000, 32'h7F800000);
    single(32'h00800000, 32'h00800000, 32'h00000000);
    single(32'hFFC00001, 32'h3F800000, 32'h7FC00000);
    single(32'h7F800000, 32'hFF800000, 32'hFF800000);
    single(32'h80000000, 32'h40000000, 32'h80000000);
    single(32'h00000001, 32'h40000000, 32'h00000000);
    // back-to-back stream with a downstream stall on cycles 4-6
    i = 0;
    cyc = 0;
    stalls = 0;
    while (i < 10 && cyc < 40) begin
      bus.out_ready = !(cyc >= 4 && cyc <= 6);
      bus.a = {i[0], 8'(127 + i), 23'h0};
      bus.b = 32'h40400000;
      exp_in = {i[0], 8'(128 + i), 23'h400000};
      bus.in_valid = 1;
      #1;
      acc = bus.in_ready;
      if (!acc) stalls++;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) i++;
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    chk("stream_sent", i, 10);
    chk("stall_cycles", stalls, 3);
    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain", 32'(q.size()), 0);
    // reset with three operations in flight
    for (int k = 0; k < 3; k++) begin
      bus.a = {1'b0, 8'(130 + k), 23'h0};
      bus.b = 32'h3F800000;
      exp_in = bus.a;
      bus.in_valid = 1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 0;
    rst_n = 0;
    #1;
    chk("mid_out_valid", 32'(bus.out_valid), 0);
    chk("mid_in_ready", 32'(bus.in_ready), 1);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("ghost", 32'(bus.out_valid), 0);
    end
    single(32'h40000000, 32'h40400000, 32'h40C00000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_mult_pipe.md
FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width; bias is 2^(EXP_W-1)-1.
REQ-002 Parameter MAN_W, default 23, stored fraction width; W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand pair a/b valid this cycle.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  W  operand A: {sign, exponent, fraction}.
REQ-008 b  input  W  operand B, same format.
REQ-009 out_valid  output  1  result valid this cycle.
REQ-010 out_ready  input  1  downstream accepts result this cycle.
REQ-011 result  output  W  product, same format.

Function
REQ-012 Pipeline SHALL have 3 register stages: S1 unpack/special-case decode, S2 mantissa product and exponent sum, S3 normalise/round/pack; latency 3 cycles from accepted input to out_valid.
REQ-013 A transfer SHALL occur on in_valid&&in_ready at input and on out_valid&&out_ready at output.
REQ-014 in_ready SHALL equal !out_valid || out_ready; when low, all stages hold contents unchanged (global stall).
REQ-015 Throughput SHALL be one result per cycle with out_ready held high.
REQ-016 Each stage SHALL carry a valid bit; bubbles propagate and never produce out_valid.
REQ-017 result and out_valid SHALL be stable while out_valid && !out_ready.
REQ-018 Sign SHALL be a[W-1] XOR b[W-1] for all non-NaN results.
REQ-019 Exponent field 0 SHALL be treated as zero (subnormals flushed; sign preserved).
REQ-020 Mantissas SHALL be {1,fraction}; product width 2*(MAN_W+1); exponent sum computed in EXP_W+2 signed bits as ea+eb-bias.
REQ-021 If product MSB set, product SHALL shift right 1 and exponent increment by 1; otherwise no shift.
REQ-022 Rounding carry out of the mantissa SHALL renormalise (fraction 0, exponent +1).
REQ-023 Final biased exponent >= 2^EXP_W-1 SHALL give signed infinity (exponent all ones, fraction 0).
REQ-024 Final biased exponent <= 0 SHALL give signed zero.
REQ-025 Either operand NaN, or infinity times zero, SHALL give canonical NaN: sign 0, exponent all ones, fraction MSB 1, rest 0.
REQ-026 Infinity times nonzero finite or infinity SHALL give signed infinity; zero times finite SHALL give signed zero.
REQ-027 Special-case results decided in S1 SHALL travel the pipeline with identical 3-cycle latency and ordering.

Reset
REQ-028 While rst_n low: all stage valid bits 0, out_valid 0, result 0, in_ready 1.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight operations; none emerge after rst_n rises.
REQ-030 First transfer SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-031 Macro FP_MULT_PIPE_RNE_EN defined: round-to-nearest-even using guard bit and sticky OR of remaining low bits; tie rounds to even fraction.
REQ-032 Macro FP_MULT_PIPE_RNE_EN undefined: truncation (round toward zero); guard/sticky logic absent; latency unchanged.

Verification
REQ-033 Defaults, out_ready=1: a=0x40000000, b=0x40400000 -> result 0x40C00000 exactly 3 cycles later; a=0x3FC00000, b=0x3FC00000 -> 0x40100000.
REQ-034 a=0x3F800001, b=0x3FC00000 -> 0x3FC00002 with FP_MULT_PIPE_RNE_EN, 0x3FC00001 without.
REQ-035 Specials: 0x7F800000*0x00000000 -> 0x7FC00000; 0xFF800000*0x40000000 -> 0xFF800000; 0x7F000000*0x7F000000 -> 0x7F800000; 0x00800000*0x00800000 -> 0x00000000.
REQ-036 Stream 10 back-to-back pairs, out_ready low on cycles 4-6: in_ready low during stall, results in order, none lost or duplicated, result stable while stalled.
REQ-037 Drive rst_n low with 3 operations in flight -> out_valid 0 immediately, no results after release, next input produces correct result 3 cycles after acceptance.
